// File: rtl/shift_add_remult_pkg.sv
// shift_add_remult_pkg: shared widths, iteration count and FSM states.
package shift_add_remult_pkg;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int ITERS  = 8;
   localparam int CNT_W  = $clog2(ITERS);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/cond_add_row.sv
// cond_add_row: enabled 16-bit add; the low APPROX_COLS columns OR without carry.
module cond_add_row
   import shift_add_remult_pkg::*;
#(
   parameter int APPROX_COLS = 0
) (
   input  logic              en_i,
   input  logic [PROD_W-1:0] a_i,
   input  logic [PROD_W-1:0] b_i,
   output logic [PROD_W-1:0] sum_o
);
   localparam logic [PROD_W-1:0] MASK = PROD_W'((1 << APPROX_COLS) - 1);
   logic [PROD_W-1:0] approx_lo;
   logic [PROD_W-1:0] exact_hi;
   assign approx_lo = (a_i | b_i) & MASK;
   // Masking both operands keeps the carry into column APPROX_COLS at zero.
   assign exact_hi  = (a_i & ~MASK) + (b_i & ~MASK);
   assign sum_o     = en_i ? (approx_lo | exact_hi) : a_i;
endmodule

// File: rtl/shift_add_remult.sv
// shift_add_remult: sequential shift-add reconstruction of q*y + r, one multiplier bit per cycle.
module shift_add_remult
   import shift_add_remult_pkg::*;
#(
   parameter int APPROX_COLS = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   q,
   input  logic [OP_W-1:0]   y,
   input  logic [OP_W-1:0]   r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] p,
   output logic              rem_err
);
   state_t            state_q, state_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [OP_W-1:0]   q_q, q_d;
   logic [OP_W-1:0]   y_q, y_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rem_err_q, rem_err_d;
   logic [PROD_W-1:0] sum;

   cond_add_row #(.APPROX_COLS(APPROX_COLS)) u_row (
      .en_i (q_q[cnt_q]),
      .a_i  (acc_q),
      .b_i  (PROD_W'(y_q) << cnt_q),
      .sum_o(sum)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      q_d       = q_q;
      y_d       = y_q;
      cnt_d     = cnt_q;
      rem_err_d = rem_err_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            state_d   = BUSY;
            acc_d     = PROD_W'(r);
            q_d       = q;
            y_d       = y;
            cnt_d     = '0;
            rem_err_d = r >= y;
         end
         BUSY: begin
            acc_d   = sum;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = cnt_q == CNT_W'(ITERS - 1) ? DONE : BUSY;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         q_q       <= '0;
         y_q       <= '0;
         cnt_q     <= '0;
         rem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         y_q       <= y_d;
         cnt_q     <= cnt_d;
         rem_err_q <= rem_err_d;
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign p         = acc_q;
   assign rem_err   = rem_err_q;
endmodule

// File: tb/tb_shift_add_remult.sv
// tb_shift_add_remult: scoreboard bench running exact and APPROX_COLS=2 instances in lockstep.
module tb_shift_add_remult;
   typedef struct {
      logic [15:0] p;
      logic [15:0] p_ax;
      logic        re;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready;
   logic [7:0]  qi, yi, ri;
   logic        in_ready, out_valid, rem_err;
   logic        in_ready_ax, out_valid_ax, rem_err_ax;
   logic [15:0] p, p_ax;
   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   shift_add_remult #(.APPROX_COLS(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .q(qi), .y(yi), .r(ri), .out_valid(out_valid), .out_ready(out_ready),
      .p(p), .rem_err(rem_err)
   );

   shift_add_remult #(.APPROX_COLS(2)) dut_ax (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_ax),
      .q(qi), .y(yi), .r(ri), .out_valid(out_valid_ax), .out_ready(out_ready),
      .p(p_ax), .rem_err(rem_err_ax)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Column-by-column reference with an explicit carry chain.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input int ac);
      logic [15:0] acc, add, s;
      logic        cy;
      acc = {8'h00, c};
      for (int i = 0; i < 8; i++) begin
         if (a[i]) begin
            add = 16'(b) << i;
            cy  = 1'b0;
            for (int k = 0; k < 16; k++) begin
               if (k < ac) begin
                  s[k] = acc[k] | add[k];
                  cy   = 1'b0;
               end else begin
                  s[k] = acc[k] ^ add[k] ^ cy;
                  cy   = (acc[k] & add[k]) | (acc[k] & cy) | (add[k] & cy);
               end
            end
            acc = s;
         end
      end
      return acc;
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", in_ready, 1);
      qi = a; yi = b; ri = c; in_valid = 1'b1;
      sb.push_back('{p: 16'(int'(a) * int'(b) + int'(c)), p_ax: model(a, b, c, 2), re: c >= b});
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         in_valid = 1'($urandom);
         qi = 8'($urandom); yi = 8'($urandom); ri = 8'($urandom);
         @(negedge clk);
         n++;
      end
      chk("latency", n, 8);
      chk("latency_ax", out_valid_ax, 1);
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      chk("p", p, e.p);
      chk("rem_err", rem_err, e.re);
      chk("p_ax", p_ax, e.p_ax);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         qi = 8'($urandom); yi = 8'($urandom); ri = 8'($urandom);
         @(negedge clk);
         chk("hold_p", p, e.p);
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_idle", in_ready, 1);
      chk("release_valid", out_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      qi = 8'h12; yi = 8'h34; ri = 8'h56;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_p", p, 0);
      chk("rst_rem_err", rem_err, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", in_ready, 1);

      run_op(8'h0A, 8'h07, 8'h03, 0);
      run_op(8'hFF, 8'hFF, 8'hFE, 0);
      run_op(8'hFF, 8'hFF, 8'hFF, 0);
      run_op(8'h01, 8'h03, 8'h01, 0);
      run_op(8'h55, 8'h00, 8'h09, 0);
      run_op(8'h00, 8'h2C, 8'h11, 0);
      run_op(8'hC3, 8'h5A, 8'h7E, 5);

      // Abort in BUSY: reset lands on the 4th iteration edge.
      qi = 8'h9D; yi = 8'h41; ri = 8'h20; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      chk("abort_idle", in_ready, 1);
      chk("abort_valid", out_valid, 0);
      chk("abort_p", p, 0);
      chk("abort_rem_err", rem_err, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end
      run_op(8'h9D, 8'h41, 8'h20, 1);

      for (int i = 0; i < 8; i++)
         run_op(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
